// File: rtl/cc_stack_unit.sv
// cc_stack_unit: condition-code unit for the SLC-3 datapath.
// Derives N/Z/P from the CPU bus. Holds the branch-enable register.
// Keeps a LIFO of saved NZP values, so that interrupt/trap entry can
// save the condition codes and the return path can restore them.
module cc_stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Load,
    input  logic [WIDTH-1:0]             bus,
    input  logic                         LD_BEN,
    input  logic [2:0]                   IR_nzp,
    input  logic                         Push,
    input  logic                         Pop,
    input  logic                         Err_clr,
    output logic [2:0]                   NZP,
    output logic                         BEN,
    output logic                         Stack_full,
    output logic                         Stack_empty,
    output logic [$clog2(DEPTH+1)-1:0]   Stack_count,
    output logic                         Err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    logic [2:0]    r_nzp;
    logic          r_ben;
    logic [CW-1:0] r_count;
    logic          r_err;
    logic [2:0]    r_mem [DEPTH];

    logic [2:0]    w_decode;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_illegal;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // A push and a pop in the same cycle are treated as a conflict. So is
    // an overflow or an underflow. Any of these leaves the stack untouched.
    assign w_push_ok = Push && !Pop && !w_full;
    assign w_pop_ok  = Pop && !Push && !w_empty;
    assign w_illegal = (Push && Pop) || (Push && w_full) || (Pop && w_empty);

    // The write slot is the current count and the read slot is the one below it.
    // The truncation is safe, because the index is used only when the operation is legal.
    assign w_wr_idx = AW'(r_count);
    assign w_rd_idx = AW'(r_count - CW'(1));

    // Sign/zero decode of the bus value. Exactly one bit is set in the result.
    always_comb begin
        // NOTE: assign a default first, so every path drives w_decode and no latch is inferred.
        w_decode = NZP_P;
        if (bus == '0) begin
            w_decode = NZP_Z;
        end else if (bus[WIDTH-1]) begin
            w_decode = NZP_N;
        end
    end

    // Condition-code, branch-enable, stack-count and sticky-error state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_nzp   <= NZP_Z;
            r_ben   <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let BEN and the stack see the pre-edge NZP,
            // even when Load or Pop updates NZP on the same edge.
            if (LD_BEN) begin
                r_ben <= |(IR_nzp & r_nzp);
            end

            if (w_pop_ok) begin
                r_nzp <= r_mem[w_rd_idx];
            end else if (Load) begin
                r_nzp <= w_decode;
            end

            if (w_push_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_ok) begin
                r_count <= r_count - CW'(1);
            end

            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (Err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Saved-NZP storage. A push writes the NZP value held before this edge.
    always_ff @(posedge Clk) begin
        // NOTE: the storage has no reset. Slots at or above the count are never read,
        // so their contents after reset do not matter.
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= r_nzp;
        end
    end

    assign NZP         = r_nzp;
    assign BEN         = r_ben;
    assign Err         = r_err;
    assign Stack_count = r_count;
    assign Stack_full  = w_full;
    assign Stack_empty = w_empty;

endmodule

// File: tb/tb_cc_stack_unit.sv
// Self-checking bench for cc_stack_unit. The bench drives directed scenarios
// and then random ones. It compares the DUT against a queue-based model of
// the condition-code stack.
module tb_cc_stack_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             Clk;
    logic             Reset;
    logic             Load;
    logic [WIDTH-1:0] bus;
    logic             LD_BEN;
    logic [2:0]       IR_nzp;
    logic             Push;
    logic             Pop;
    logic             Err_clr;
    logic [2:0]       NZP;
    logic             BEN;
    logic             Stack_full;
    logic             Stack_empty;
    logic [2:0]       Stack_count;
    logic             Err;

    // Narrow-bus instance, used for the 8-bit decode checks.
    logic             Load8;
    logic [7:0]       bus8;
    logic [2:0]       NZP8;
    logic             BEN8;
    logic             full8;
    logic             empty8;
    logic [2:0]       count8;
    logic             err8;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [2:0] q_stack[$];
    logic [2:0] m_nzp;
    logic       m_ben;
    logic       m_err;

    cc_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Load(Load), .bus(bus), .LD_BEN(LD_BEN),
        .IR_nzp(IR_nzp), .Push(Push), .Pop(Pop), .Err_clr(Err_clr),
        .NZP(NZP), .BEN(BEN), .Stack_full(Stack_full), .Stack_empty(Stack_empty),
        .Stack_count(Stack_count), .Err(Err)
    );

    cc_stack_unit #(.WIDTH(8), .DEPTH(DEPTH)) dut8 (
        .Clk(Clk), .Reset(Reset), .Load(Load8), .bus(bus8), .LD_BEN(1'b0),
        .IR_nzp(3'b000), .Push(1'b0), .Pop(1'b0), .Err_clr(1'b0),
        .NZP(NZP8), .BEN(BEN8), .Stack_full(full8), .Stack_empty(empty8),
        .Stack_count(count8), .Err(err8)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_decode(input logic [WIDTH-1:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 0)         return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_reset();
        q_stack.delete();
        m_nzp = 3'b010;
        m_ben = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".nzp"},   {29'd0, NZP}, {29'd0, m_nzp});
        check({tag, ".ben"},   {31'd0, BEN}, {31'd0, m_ben});
        check({tag, ".count"}, {29'd0, Stack_count}, q_stack.size());
        check({tag, ".full"},  {31'd0, Stack_full}, {31'd0, q_stack.size() == DEPTH});
        check({tag, ".empty"}, {31'd0, Stack_empty}, {31'd0, q_stack.size() == 0});
        check({tag, ".err"},   {31'd0, Err}, {31'd0, m_err});
    endtask

    // Drive one cycle of strobes, update the model at the edge, then check 1 time unit later.
    task automatic cyc(input string tag, input logic ld, input logic [WIDTH-1:0] b,
                       input logic lb, input logic [2:0] ir, input logic ps,
                       input logic pp, input logic clr);
        logic [2:0] old_nzp;
        logic       illegal;
        Load = ld; bus = b; LD_BEN = lb; IR_nzp = ir; Push = ps; Pop = pp; Err_clr = clr;
        @(posedge Clk);
        old_nzp = m_nzp;
        illegal = (ps && pp) || (ps && q_stack.size() == DEPTH) || (pp && q_stack.size() == 0);
        if (lb) m_ben = |(ir & old_nzp);
        if (ps && !pp && q_stack.size() < DEPTH) q_stack.push_back(old_nzp);
        if (pp && !ps && q_stack.size() > 0) m_nzp = q_stack.pop_back();
        else if (ld) m_nzp = ref_decode(b);
        if (illegal) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        #1;
        check_all(tag);
        Load = 0; LD_BEN = 0; Push = 0; Pop = 0; Err_clr = 0; IR_nzp = 0;
        @(negedge Clk);
    endtask

    initial begin
        logic [WIDTH-1:0] rb;
        Reset = 1'b0; Load = 0; bus = 0; LD_BEN = 0; IR_nzp = 0;
        Push = 0; Pop = 0; Err_clr = 0; Load8 = 0; bus8 = 0;
        model_reset();
        #12;
        check_all("reset0");
        @(negedge Clk);
        Reset = 1'b1;

        // Decode
        cyc("dec_0000", 1, 16'h0000, 0, 0, 0, 0, 0); check("dec_0000.c", {29'd0, NZP}, 32'h2);
        cyc("dec_8001", 1, 16'h8001, 0, 0, 0, 0, 0); check("dec_8001.c", {29'd0, NZP}, 32'h4);
        cyc("dec_7fff", 1, 16'h7FFF, 0, 0, 0, 0, 0); check("dec_7fff.c", {29'd0, NZP}, 32'h1);
        cyc("dec_ffff", 1, 16'hFFFF, 0, 0, 0, 0, 0); check("dec_ffff.c", {29'd0, NZP}, 32'h4);

        // BEN
        cyc("ben_n1", 0, 0, 1, 3'b100, 0, 0, 0); check("ben_n1.c", {31'd0, BEN}, 32'd1);
        cyc("ben_n0", 0, 0, 1, 3'b011, 0, 0, 0); check("ben_n0.c", {31'd0, BEN}, 32'd0);
        cyc("ben_set", 0, 0, 1, 3'b100, 0, 0, 0);
        cyc("ben_ldp", 1, 16'h0001, 0, 0, 0, 0, 0);
        cyc("ben_old", 1, 16'h0000, 1, 3'b010, 0, 0, 0);
        check("ben_old.c", {31'd0, BEN}, 32'd0);

        // LIFO
        cyc("lifo_l5", 1, 16'h0005, 0, 0, 0, 0, 0); cyc("lifo_p1", 0, 0, 0, 0, 1, 0, 0);
        cyc("lifo_l0", 1, 16'h0000, 0, 0, 0, 0, 0); cyc("lifo_p2", 0, 0, 0, 0, 1, 0, 0);
        cyc("lifo_l8", 1, 16'h8000, 0, 0, 0, 0, 0); cyc("lifo_p3", 0, 0, 0, 0, 1, 0, 0);
        check("lifo_cnt3", {29'd0, Stack_count}, 32'd3);
        cyc("lifo_pop1", 0, 0, 0, 0, 0, 1, 0); check("lifo_pop1.c", {29'd0, NZP}, 32'h4);
        cyc("lifo_pop2", 0, 0, 0, 0, 0, 1, 0); check("lifo_pop2.c", {29'd0, NZP}, 32'h2);
        cyc("lifo_pop3", 0, 0, 0, 0, 0, 1, 0); check("lifo_pop3.c", {29'd0, NZP}, 32'h1);
        check("lifo_empty", {31'd0, Stack_empty}, 32'd1);
        check("lifo_err", {31'd0, Err}, 32'd0);

        // Boundaries
        for (int i = 0; i < 4; i++) cyc("fill", 0, 0, 0, 0, 1, 0, 0);
        check("full_flag", {31'd0, Stack_full}, 32'd1);
        cyc("overflow", 0, 0, 0, 0, 1, 0, 0);
        check("overflow.err", {31'd0, Err}, 32'd1);
        check("overflow.cnt", {29'd0, Stack_count}, 32'd4);
        for (int i = 0; i < 4; i++) cyc("drain", 0, 0, 0, 0, 0, 1, 0);
        cyc("clr", 0, 0, 0, 0, 0, 0, 1);
        check("clr.err", {31'd0, Err}, 32'd0);
        cyc("underflow_ld", 1, 16'h0001, 0, 0, 0, 1, 0);
        check("underflow.err", {31'd0, Err}, 32'd1);
        check("underflow.nzp", {29'd0, NZP}, 32'h1);
        cyc("clr2", 0, 0, 0, 0, 0, 0, 1);
        cyc("pa", 0, 0, 0, 0, 1, 0, 0); cyc("pb", 0, 0, 0, 0, 1, 0, 0);
        cyc("pushpop", 0, 0, 0, 0, 1, 1, 0);
        check("pushpop.cnt", {29'd0, Stack_count}, 32'd2);
        check("pushpop.err", {31'd0, Err}, 32'd1);

        // Async reset mid-run with count=2 and Err=1
        cyc("ben_hi", 1, 16'h8000, 1, 3'b111, 0, 0, 0);
        #3;
        Reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge Clk);
        Reset = 1'b1;

        // Push together with Load, then Pop, then Err_clr with an illegal Pop
        cyc("pl_l0", 1, 16'h0000, 0, 0, 0, 0, 0);
        cyc("pl_push", 1, 16'hFFFF, 0, 0, 1, 0, 0);
        check("pl_push.nzp", {29'd0, NZP}, 32'h4);
        cyc("pl_pop", 0, 0, 0, 0, 0, 1, 0);
        check("pl_pop.nzp", {29'd0, NZP}, 32'h2);
        cyc("clr_vs_set", 0, 0, 0, 0, 0, 1, 1);
        check("clr_vs_set.err", {31'd0, Err}, 32'd1);

        // Random
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0: rb = 16'h0000;
                1: rb = 16'h8000;
                2: rb = 16'h7FFF;
                default: rb = 16'($urandom);
            endcase
            cyc("rand", ($urandom_range(0, 1) == 1), rb, ($urandom_range(0, 2) == 0),
                3'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0));
        end

        // 8-bit bus decode
        Load8 = 1; bus8 = 8'h80; @(posedge Clk); #1; check("w8_80", {29'd0, NZP8}, 32'h4);
        @(negedge Clk); bus8 = 8'h00; @(posedge Clk); #1; check("w8_00", {29'd0, NZP8}, 32'h2);
        @(negedge Clk); bus8 = 8'h7F; @(posedge Clk); #1; check("w8_7f", {29'd0, NZP8}, 32'h1);
        @(negedge Clk); Load8 = 0; bus8 = 8'hFF; @(posedge Clk); #1;
        check("w8_hold", {29'd0, NZP8}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_stack_unit.md
# cc_stack_unit

Parametrised condition-code unit for the SLC-3 datapath. It derives N/Z/P from a WIDTH-bit bus value, holds the branch-enable (BEN) register, and keeps a hardware stack of saved condition codes so the control FSM can push NZP on interrupt/trap entry and restore it on return. It sits beside the register file, watches the CPU bus, and feeds NZP and BEN to the control state machine.

## Interface
Parameters:
- WIDTH, 16, bus width; sign bit is bus[WIDTH-1]; WIDTH >= 2
- DEPTH, 4, saved-NZP stack entries; DEPTH >= 1

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset (Reset=0 resets immediately)
- Load  in  1  capture NZP from bus this cycle
- bus  in  WIDTH  CPU bus value
- LD_BEN  in  1  load BEN register
- IR_nzp  in  3  branch condition field (IR[11:9]: n,z,p)
- Push  in  1  push current NZP onto stack
- Pop  in  1  pop top of stack into NZP
- Err_clr  in  1  clear sticky error flag
- NZP  out  3  condition code {N,Z,P}
- BEN  out  1  registered branch enable
- Stack_full  out  1  count == DEPTH
- Stack_empty  out  1  count == 0
- Stack_count  out  $clog2(DEPTH+1)  entries held
- Err  out  1  sticky illegal-stack-operation flag

## Operation
- Decode (combinational from bus): bus == 0 -> 3'b010; bus[WIDTH-1]=1 -> 3'b100; else 3'b001. Exactly one bit set.
- NZP register next value, priority order: legal Pop -> stack top; else Load -> decode(bus); else hold.
- BEN: on LD_BEN, BEN <= |(IR_nzp & NZP) using the registered NZP (pre-update value if Load/Pop same cycle). Else hold.
- Push (legal when not full, Pop=0): mem[count] <= current registered NZP (pre-update), count++. A simultaneous Load still updates NZP; stacked value is the old one.
- Pop (legal when not empty, Push=0): NZP <= mem[count-1], count--. Pop overrides Load.
- Illegal ops, each sets Err=1 and leaves stack and count unchanged: Push when full; Pop when empty; Push and Pop together. Illegal Pop does not block Load (Load proceeds normally).
- Err clears on Err_clr only if no new illegal op that cycle (set wins).
- Stack is LIFO; entries above count are don't-care, never read.
- Stack_full/Stack_empty/Stack_count are combinational from the count register.

## Timing
- Reset (async assert, any time, including mid-push/pop): NZP=3'b010, BEN=0, count=0, Stack_empty=1, Stack_full=0, Err=0. Memory contents undefined, unused.
- Reset release synchronous to design intent; first operation takes effect on first rising edge with Reset=1.
- Load/Pop -> NZP valid 1 cycle after the edge (registered, no bypass).
- LD_BEN -> BEN valid after the edge; LD_BEN issued the cycle after Load sees the new NZP.
- Push then Pop on consecutive cycles returns the NZP held at the Push edge.
- Stack flags update on the same edge as count.
- No backpressure/handshake; all inputs single-cycle strobes, sampled every edge.

## Test plan
- Reset: Reset=0 mid-run with count=2, Err=1 -> immediately NZP=010, BEN=0, count=0, Err=0, Stack_empty=1.
- Decode: Load with bus=16'h0000, 16'h8001, 16'h7FFF, 16'hFFFF -> NZP 010, 100, 001, 100 one cycle later each; repeat at WIDTH=8 with 8'h80 -> 100.
- BEN: NZP=100, LD_BEN with IR_nzp=3'b100 -> BEN=1; IR_nzp=3'b011 -> BEN=0; Load(bus=0) and LD_BEN(IR_nzp=010) same cycle with old NZP=001 -> BEN=0.
- Stack LIFO (DEPTH=4): Load 5/push, Load 0/push, Load 8000h/push -> count=3; Pop x3 -> NZP 100, 010, 001; Stack_empty=1; Err=0.
- Boundaries: push 4 times -> Stack_full=1; 5th Push -> Err=1, count=4; Pop on empty with Load(bus=1) -> Err=1, NZP=001; Push+Pop together at count=2 -> count=2, Err=1.
- Push+Load same cycle with NZP=010, bus=FFFFh -> NZP=100, then Pop -> NZP=010; Err_clr with simultaneous illegal Pop -> Err stays 1.
